// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered output.
module sync_fifo_param #(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   push,
   input  logic                   pop,
   output logic [WIDTH-1:0]       data_out,
   output logic                   fifo_empty,
   output logic                   fifo_full,
   output logic                   almost_empty,
   output logic                   almost_full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [31:0]      count_ext;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             aempty_q, aempty_d;
   logic             afull_q, afull_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             push_ok, pop_ok;

   // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
   always_comb begin
      push_ok   = push & (~full_q | pop);
      pop_ok    = pop & ~empty_q;
      wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d   = count_q + CW'(push_ok) - CW'(pop_ok);
      count_ext = 32'(count_d);
      empty_d   = (count_d == '0);
      full_d    = (count_d == CW'(DEPTH));
      aempty_d  = (count_ext <= 32'(AE_LEVEL));
      afull_d   = (count_ext >= 32'(AF_LEVEL));
      ovf_d     = push & full_q & ~pop;
      udf_d     = pop & empty_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         aempty_q <= aempty_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

`ifdef FIFO_FWFT_EN
   assign data_out = mem_q[rd_ptr_q];
`else
   logic [WIDTH-1:0] dout_q;

   // Non-blocking read of the head gives read-before-write when full with push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q <= '0;
      end else if (pop_ok) begin
         dout_q <= mem_q[rd_ptr_q];
      end
   end

   assign data_out = dout_q;
`endif

   assign fifo_empty   = empty_q;
   assign fifo_full    = full_q;
   assign almost_empty = aempty_q;
   assign almost_full  = afull_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=4, DEPTH=4) against a queue-based model.
// Covers directed test-plan sequences plus biased random traffic with occasional resets.
module tb_sync_fifo_param;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int AF    = 2;
   localparam int AE    = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] data_in = '0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             fifo_empty, fifo_full, almost_empty, almost_full;
   logic [2:0]       count;
   logic             overflow, underflow;

   int checks = 0;
   int errors = 0;
   string phase = "init";

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] m_dout = '0;
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;

   sync_fifo_param #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AF_LEVEL(AF),
      .AE_LEVEL(AE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .push(push),
      .pop(pop),
      .data_out(data_out),
      .fifo_empty(fifo_empty),
      .fifo_full(fifo_full),
      .almost_empty(almost_empty),
      .almost_full(almost_full),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s:%s got %0h expected %0h at %0t", phase, tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = model_q.size();
      check_eq("count",        int'(count),        n);
      check_eq("fifo_empty",   int'(fifo_empty),   int'(n == 0));
      check_eq("fifo_full",    int'(fifo_full),    int'(n == DEPTH));
      check_eq("almost_empty", int'(almost_empty), int'(n <= AE));
      check_eq("almost_full",  int'(almost_full),  int'(n >= AF));
      check_eq("overflow",     int'(overflow),     int'(m_ovf));
      check_eq("underflow",    int'(underflow),    int'(m_udf));
`ifdef FIFO_FWFT_EN
      if (n > 0) check_eq("data_out", int'(data_out), int'(model_q[0]));
`else
      check_eq("data_out", int'(data_out), int'(m_dout));
`endif
   endtask

   // Drive one cycle, advance the model on the pre-edge occupancy, then check.
   task automatic step(input logic rst, input logic ps, input logic pp, input logic [WIDTH-1:0] d);
      int n;
      reset   = rst;
      push    = ps;
      pop     = pp;
      data_in = d;
      @(posedge clk);
      n = model_q.size();
      if (rst) begin
         model_q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         m_ovf = ps && (n == DEPTH) && !pp;
         m_udf = pp && (n == 0);
         if (pp && n > 0) m_dout = model_q.pop_front();
         if (ps && (n < DEPTH || pp)) model_q.push_back(d);
      end
      #1;
      check_all();
   endtask

   initial begin
      int bias;
      logic [WIDTH-1:0] fill_vals [4];
      fill_vals[0] = 4'h2;
      fill_vals[1] = 4'hA;
      fill_vals[2] = 4'hE;
      fill_vals[3] = 4'h6;

      phase = "reset";
      step(1'b1, 1'b1, 1'b0, 4'h5);
      step(1'b1, 1'b1, 1'b0, 4'h8);

      phase = "fill";
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, fill_vals[i]);
      phase = "overflow";
      step(1'b0, 1'b1, 1'b0, 4'h3);
      step(1'b0, 1'b0, 1'b0, 4'h0);

      phase = "drain";
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
      phase = "underflow";
      step(1'b0, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 1'b0, 4'h0);

      phase = "wrap";
      step(1'b0, 1'b1, 1'b0, 4'hB);
      step(1'b0, 1'b1, 1'b0, 4'hC);
      for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 1'b1, 4'(i));
      step(1'b0, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 1'b1, 4'h0);

      phase = "full_pushpop";
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'(4'hC + i));
      step(1'b0, 1'b1, 1'b1, 4'h5);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'h0);

      phase = "empty_pushpop";
      step(1'b0, 1'b1, 1'b1, 4'h7);
      step(1'b0, 1'b0, 1'b1, 4'h0);

      phase = "fwft_head";
      step(1'b0, 1'b1, 1'b0, 4'h9);
      step(1'b0, 1'b1, 1'b0, 4'h4);
      step(1'b0, 1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 1'b1, 4'h0);

      phase = "midreset";
      step(1'b0, 1'b1, 1'b0, 4'h1);
      step(1'b1, 1'b1, 1'b1, 4'h2);
      step(1'b0, 1'b0, 1'b0, 4'h0);

      phase = "random";
      bias = 70;
      for (int i = 0; i < 600; i++) begin
         if (i % 40 == 0) bias = (bias == 70) ? 30 : 70;
         step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 100 - bias) ? 1'b1 : 1'b0,
              4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
